// File: rtl/register_params.sv
// Shared register-file widths and the write-back payload type used by
// global_register and its upstream write-back arbiter.
package register_params;

   localparam int unsigned REGISTER_DESCRIPTOR_WIDTH = 5;
   localparam int unsigned OPERAND_WIDTH             = 32;
   localparam int unsigned NUM_WRITE_BACK_SOURCES    = 2;

   typedef struct packed {
      logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_index;
      logic [OPERAND_WIDTH-1:0]             result;
   } write_back_entry_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the
// pointer (wrapping); the pointer moves past the winner only when a grant occurs.
module round_robin_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQUESTERS-1:0] request,
   output logic [NUM_REQUESTERS-1:0] grant_c
);

   localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic             any_grant;
   int unsigned      idx;

   // Search upward from the pointer, modulo the requester count
   always_comb begin
      grant_c   = '0;
      any_grant = 1'b0;
      ptr_next  = ptr;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         idx = (32'(ptr) + k) % NUM_REQUESTERS;
         if (!any_grant && request[PTR_W'(idx)]) begin
            grant_c[PTR_W'(idx)] = 1'b1;
            any_grant            = 1'b1;
            ptr_next             = PTR_W'((idx + 1) % NUM_REQUESTERS);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (any_grant) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/write_back_arbiter.sv
// Serialises results from several execution units into the single write-back
// port of global_register using one-entry holding buffers and round-robin grant.
module write_back_arbiter
   import register_params::*;
#(
   parameter int unsigned NUM_SOURCES               = NUM_WRITE_BACK_SOURCES,
   parameter int unsigned REGISTER_DESCRIPTOR_WIDTH = register_params::REGISTER_DESCRIPTOR_WIDTH,
   parameter int unsigned OPERAND_WIDTH             = register_params::OPERAND_WIDTH
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [NUM_SOURCES-1:0]                         source_valid_input,
   output logic [NUM_SOURCES-1:0]                         source_ready_output,
   input  logic [NUM_SOURCES*REGISTER_DESCRIPTOR_WIDTH-1:0] source_register_input,
   input  logic [NUM_SOURCES*OPERAND_WIDTH-1:0]           source_result_input,
   output logic                                           write_back_output,
   output logic [REGISTER_DESCRIPTOR_WIDTH-1:0]           write_back_register_output,
   output logic [OPERAND_WIDTH-1:0]                       result_output,
   output logic                                           busy_output
);

   localparam int unsigned RW = REGISTER_DESCRIPTOR_WIDTH;
   localparam int unsigned OW = OPERAND_WIDTH;

   logic [NUM_SOURCES-1:0] full;
   logic [NUM_SOURCES-1:0] grant;
   logic [NUM_SOURCES-1:0] accept;
   logic [RW-1:0]          buf_reg [NUM_SOURCES];
   logic [OW-1:0]          buf_res [NUM_SOURCES];
   logic [RW-1:0]          sel_reg;
   logic [OW-1:0]          sel_res;

   round_robin_arbiter #(
      .NUM_REQUESTERS (NUM_SOURCES)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .request (full),
      .grant_c (grant)
   );

   // A granted buffer drains this edge, so it can take a new result in the same cycle
   assign source_ready_output = {NUM_SOURCES{rst}} & (~full | grant);
   assign busy_output         = |full;

   // Register-0 transfers are acknowledged but never buffered
   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         accept[i] = source_valid_input[i] & source_ready_output[i]
                     & (source_register_input[i*RW +: RW] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            buf_reg[i] <= '0;
            buf_res[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (accept[i]) begin
               full[i]    <= 1'b1;
               buf_reg[i] <= source_register_input[i*RW +: RW];
               buf_res[i] <= source_result_input[i*OW +: OW];
            end else if (grant[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   // One-hot grant lets a plain OR select the winning entry
   always_comb begin
      sel_reg = '0;
      sel_res = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (grant[i]) begin
            sel_reg = sel_reg | buf_reg[i];
            sel_res = sel_res | buf_res[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_back_output          <= 1'b0;
         write_back_register_output <= '0;
         result_output              <= '0;
      end else begin
         write_back_output <= |grant;
         if (|grant) begin
            write_back_register_output <= sel_reg;
            result_output              <= sel_res;
         end
      end
   end

endmodule

// File: doc/write_back_arbiter.md
Name: write_back_arbiter

Overview:
- Collects results from several execution units and serialises them into the single write-back port of global_register, at most one register write per cycle.
- Each source has a one-entry holding buffer, a valid/ready handshake and round-robin fair arbitration.
- Sits directly upstream of global_register and drives its write_back_input, write_back_register_input and result_input.

Parameters:
- NUM_SOURCES, default 2: number of result producers.
- REGISTER_DESCRIPTOR_WIDTH, default register_params::REGISTER_DESCRIPTOR_WIDTH (5): register index width.
- OPERAND_WIDTH, default register_params::OPERAND_WIDTH (32): result width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- source_valid_input  input  NUM_SOURCES  source i presents a result.
- source_ready_output  output  NUM_SOURCES  source i may transfer this cycle.
- source_register_input  input  NUM_SOURCES*REGISTER_DESCRIPTOR_WIDTH  destination index per source; slice i is source i.
- source_result_input  input  NUM_SOURCES*OPERAND_WIDTH  result value per source.
- write_back_output  output  1  registered write strobe to global_register.
- write_back_register_output  output  REGISTER_DESCRIPTOR_WIDTH  registered destination index.
- result_output  output  OPERAND_WIDTH  registered write data.
- busy_output  output  1  any holding buffer occupied.

Behaviour:
- Reset (rst low, asynchronous): all buffers empty, round-robin pointer 0, write_back_output 0, write_back_register_output 0, result_output 0, busy_output 0. source_ready_output is forced to 0 while rst is low.
- Handshake: a transfer occurs on an edge where valid_i and ready_i are both 1. Data must be held stable while valid_i=1 and ready_i=0.
- Ready is combinational: ready_i = rst & (~full_i | grant_i). This allows a same-cycle drain and refill, giving one transfer per cycle per source at full throughput.
- Register 0: a transfer with index 0 is acknowledged but never buffered and never written. It has no effect on arbitration.
- Arbitration is combinational from the buffer full flags. grant_i goes to the first full buffer found searching from the pointer upward, modulo NUM_SOURCES.
- Grant edge: on the edge the grant happens, the output registers load {1, index, result} and buffer i clears, or reloads if a new transfer occurs the same edge.
- Pointer update: after granting i, the pointer becomes (i+1) mod NUM_SOURCES. With no grant the pointer is unchanged, write_back_output becomes 0, and the index/result outputs hold their last values.
- Latency: transfer at edge N, buffer full after N, write_back_output high during the cycle after edge N+1. This is 2 edges minimum with no contention.
- write_back_output is a one-cycle strobe per write. Back-to-back strobes are allowed with no gap.
- Same destination from multiple sources: both writes happen in arbitration order on successive cycles, with no merging. The later write wins in global_register.
- No buffered entry is ever dropped or duplicated. Worst-case wait for a full buffer is NUM_SOURCES-1 cycles.
- busy_output = OR of buffer full flags (combinational).
- Reset mid-operation: buffers and outputs clear immediately. No stale write issues after rst rises.

Decomposition:
- register_params gains two items:
  - typedef write_back_entry_t, a packed struct {register index, result};
  - constant NUM_WRITE_BACK_SOURCES = 2.
- Sub-module round_robin_arbiter(NUM_REQUESTERS): request vector in, one-hot grant out, pointer register inside, advancing only on a grant.
- Holding buffers, handshake and output registers stay in write_back_arbiter.

Test Plan:
- Reset: hold rst=0 with all valid=1 -> ready=00, write_back_output=0, busy=0. Release -> ready=11, no strobe.
- Single write: src0 valid, reg 00001, ABCDABCD for one cycle -> exactly one strobe two edges later with reg 00001 and result ABCDABCD. A connected global_register then reads ABCDABCD on operand0 for reg 1.
- Contention: src0 (reg 00010, BCDEBCDE) and src1 (reg 00011, CDEFCDEF) valid on the same edge, pointer 0 -> strobes on consecutive cycles, reg 2 then reg 3. Both values read back correctly.
- Fairness: both sources valid continuously for 8 cycles with incrementing data -> grants alternate 0,1,0,1. Ready alternates accordingly. 8 strobes in order with no loss or duplication; busy stays 1 until the last drain.
- Zero register: src0 reg 00000, FFFFFFFF -> ready=1 and the transfer is accepted, write_back_output never asserts, register 0 still reads 0.
- Mid-operation reset: both buffers full, pull rst low between edges -> all outputs 0 immediately. After release, no strobe occurs until new transfers.
